// File: rtl/ppc_decode_pkg.sv
// Shared decode definitions for the PowerPC integer load/store decode path:
// primary opcodes, DS extended opcodes, access sizes, instruction-format
// indices and the packed micro-op stored in the decode output queue.
package ppc_decode_pkg;

  // Primary opcodes of the DS-form doubleword load/store groups
  localparam logic [5:0] OP_DS_LOAD  = 6'd58;
  localparam logic [5:0] OP_DS_STORE = 6'd62;

  // DS extended opcode (instruction bits 30:31) under OP_DS_LOAD
  localparam logic [1:0] XOP_LD      = 2'd0;
  localparam logic [1:0] XOP_LDU     = 2'd1;
  localparam logic [1:0] XOP_LWA     = 2'd2;

  // DS extended opcode under OP_DS_STORE
  localparam logic [1:0] XOP_STD     = 2'd0;
  localparam logic [1:0] XOP_STDU    = 2'd1;
  localparam logic [1:0] XOP_STQ     = 2'd2;

  // Access size, log2 of the byte count
  localparam logic [2:0] SIZE_BYTE   = 3'd0;
  localparam logic [2:0] SIZE_HALF   = 3'd1;
  localparam logic [2:0] SIZE_WORD   = 3'd2;
  localparam logic [2:0] SIZE_DWORD  = 3'd3;
  localparam logic [2:0] SIZE_QUAD   = 3'd4;

  // Instruction-format index shared by the format-split logic
  typedef enum logic [4:0] {
    FMT_INVALID,
    FMT_I,
    FMT_B,
    FMT_SC,
    FMT_D,
    FMT_DQ,
    FMT_DS,
    FMT_DX,
    FMT_X,
    FMT_XL,
    FMT_XFX,
    FMT_XFL,
    FMT_XX1,
    FMT_XX2,
    FMT_XX3,
    FMT_XX4,
    FMT_XS,
    FMT_XO,
    FMT_A,
    FMT_M,
    FMT_MD,
    FMT_MDS,
    FMT_VA,
    FMT_VC,
    FMT_VX,
    FMT_EVX,
    FMT_EVS,
    FMT_Z22,
    FMT_Z23
  } format_e;

  // Decoded micro-op payload. The displacement is kept as the raw 16-bit
  // {DS,2'b00} and sign-extended to the output width only at the queue head,
  // so the stored entry does not depend on the output width parameter.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [1:0]  xop;
    logic [4:0]  reg1;
    logic [4:0]  reg2;
    logic        reg2_val_or_zero;
    logic [15:0] imm;
    logic        is_load;
    logic        is_store;
    logic        update;
    logic        sign_ext;
    logic [2:0]  size;
    logic        illegal;
  } uop_t;

  // Byte displacement of a DS-form instruction: word offset times four
  function automatic logic [15:0] ds_disp(input logic [13:0] ds);
    return {ds, 2'b00};
  endfunction

endpackage

// File: rtl/ds_format_decode_stage_if.sv
// Bus bundle between the fetch/format-split side and the LSU issue side.
//
// Handshake: on each side a transfer happens on a rising clock edge where
// valid and ready are both 1. A producer holding valid=1 keeps its payload
// stable until the transfer; ready may depend combinationally on the
// consumer's ready but never on the same side's valid.
interface ds_format_decode_stage_if #(
  parameter int instructionWidth = 32,
  parameter int addressSize      = 64,
  parameter int immOutWidth      = 64
);

  // Fetch side
  logic                        valid_i;
  logic                        ready_o;
  logic [instructionWidth-1:0] instruction_i;
  logic [addressSize-1:0]      address_i;

  // Issue side
  logic                        valid_o;
  logic                        ready_i;
  logic [5:0]                  opcode_o;
  logic [1:0]                  xop_o;
  logic [4:0]                  reg1_o;
  logic [4:0]                  reg2_o;
  logic                        reg2ValOrZero_o;
  logic [immOutWidth-1:0]      imm_o;
  logic                        isLoad_o;
  logic                        isStore_o;
  logic                        update_o;
  logic                        signExt_o;
  logic [2:0]                  size_o;
  logic                        illegal_o;
  logic [addressSize-1:0]      address_o;

  // Environment view: drives instructions in and consumes micro-ops
  modport master (
    output valid_i, instruction_i, address_i, ready_i,
    input  ready_o, valid_o, opcode_o, xop_o, reg1_o, reg2_o,
           reg2ValOrZero_o, imm_o, isLoad_o, isStore_o, update_o,
           signExt_o, size_o, illegal_o, address_o
  );

  // Decode stage view
  modport slave (
    input  valid_i, instruction_i, address_i, ready_i,
    output ready_o, valid_o, opcode_o, xop_o, reg1_o, reg2_o,
           reg2ValOrZero_o, imm_o, isLoad_o, isStore_o, update_o,
           signExt_o, size_o, illegal_o, address_o
  );

endinterface

// File: rtl/ds_decode_comb.sv
// Purely combinational DS-form decoder: instruction word in, micro-op out.
// Fields use big-endian bit numbering, bit 0 being the instruction MSB.
module ds_decode_comb
  import ppc_decode_pkg::*;
#(
  parameter int instructionWidth = 32
) (
  input  logic [instructionWidth-1:0] instruction,
  output uop_t                        uop,
  output logic                        is_ds
);

  localparam int W = instructionWidth;

  logic [5:0]  opcode;
  logic [4:0]  rt;
  logic [4:0]  ra;
  logic [13:0] ds;
  logic [1:0]  xop;

  // Big-endian field extraction: bits 0:5, 6:10, 11:15, 16:29, 30:31
  assign opcode = instruction[W-1  -: 6];
  assign rt     = instruction[W-7  -: 5];
  assign ra     = instruction[W-12 -: 5];
  assign ds     = instruction[W-17 -: 14];
  assign xop    = instruction[W-31 -: 2];

  // Classify the opcode/xop pair and flag illegal forms; register and
  // displacement fields are always passed through as decoded.
  always_comb begin
    uop        = '0;
    is_ds      = 1'b0;
    uop.opcode = opcode;
    uop.xop    = xop;
    uop.reg1   = rt;
    uop.reg2   = ra;
    uop.imm    = ds_disp(ds);
    case (opcode)
      OP_DS_LOAD: begin
        is_ds = 1'b1;
        case (xop)
          XOP_LD: begin
            uop.is_load          = 1'b1;
            uop.size             = SIZE_DWORD;
            uop.reg2_val_or_zero = 1'b1;
          end
          XOP_LDU: begin
            // Update form writes RA back, so RA=0 and RA=RT are undefined
            uop.is_load = 1'b1;
            uop.update  = 1'b1;
            uop.size    = SIZE_DWORD;
            uop.illegal = (ra == 5'd0) || (ra == rt);
          end
          XOP_LWA: begin
            uop.is_load          = 1'b1;
            uop.sign_ext         = 1'b1;
            uop.size             = SIZE_WORD;
            uop.reg2_val_or_zero = 1'b1;
          end
          default: uop.illegal = 1'b1;
        endcase
      end
      OP_DS_STORE: begin
        is_ds = 1'b1;
        case (xop)
          XOP_STD: begin
            uop.is_store         = 1'b1;
            uop.size             = SIZE_DWORD;
            uop.reg2_val_or_zero = 1'b1;
          end
          XOP_STDU: begin
            uop.is_store = 1'b1;
            uop.update   = 1'b1;
            uop.size     = SIZE_DWORD;
            uop.illegal  = (ra == 5'd0);
          end
          XOP_STQ: begin
            // Quadword store names an even/odd register pair starting at RS
            uop.is_store         = 1'b1;
            uop.size             = SIZE_QUAD;
            uop.reg2_val_or_zero = 1'b1;
            uop.illegal          = rt[0];
          end
          default: uop.illegal = 1'b1;
        endcase
      end
      default: uop.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sync_fifo_ready_valid.sv
// Generic synchronous FIFO with valid/ready on both sides. Pointers carry
// one extra wrap bit so full and empty are told apart without a counter.
// A full FIFO still accepts when the head is being popped in the same cycle.
module sync_fifo_ready_valid #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Occupancy flags and handshake qualifiers
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    out_valid = resetn && !empty;
    in_ready  = resetn && !flush && (!full || out_ready);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready && !flush;
    out_data  = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; reset and flush both empty the queue, flush beats push/pop
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write at the tail; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/ds_format_decode_stage.sv
// DS-form decode stage for the integer load/store path. Decodes ld/ldu/lwa
// and std/stdu/stq into a micro-op, queues it with its instruction address
// and presents the queue head to the load/store issue queue.
module ds_format_decode_stage
  import ppc_decode_pkg::*;
#(
  parameter int instructionWidth = 32,
  parameter int addressSize      = 64,
  parameter int immOutWidth      = 64,
  parameter int DEPTH            = 2,
  parameter int DROP_NON_DS      = 1
) (
  input  logic                      clock_i,
  input  logic                      resetn_i,
  input  logic                      flush_i,
  ds_format_decode_stage_if.slave   bus
);

  localparam int UOP_W   = $bits(uop_t);
  localparam int ENTRY_W = addressSize + UOP_W;

  uop_t                   dec_uop;
  logic                   dec_is_ds;
  logic                   keep;
  logic                   fifo_in_ready;
  logic                   head_valid;
  logic [ENTRY_W-1:0]     wr_entry;
  logic [ENTRY_W-1:0]     head_entry;
  uop_t                   head_uop;
  logic [addressSize-1:0] head_addr;

  ds_decode_comb #(
    .instructionWidth (instructionWidth)
  ) u_decode (
    .instruction (bus.instruction_i),
    .uop         (dec_uop),
    .is_ds       (dec_is_ds)
  );

  // Non-DS words are either dropped (accepted, never queued) or queued as
  // illegal; the upstream ready does not depend on which happens.
  always_comb begin
    keep     = dec_is_ds || (DROP_NON_DS == 0);
    wr_entry = {bus.address_i, dec_uop};
  end

  sync_fifo_ready_valid #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clock_i),
    .resetn    (resetn_i),
    .flush     (flush_i),
    .in_valid  (bus.valid_i && keep),
    .in_ready  (fifo_in_ready),
    .in_data   (wr_entry),
    .out_valid (head_valid),
    .out_ready (bus.ready_i),
    .out_data  (head_entry)
  );

  // Present the queue head; payload reads as zero whenever nothing is valid
  always_comb begin
    head_addr           = head_entry[ENTRY_W-1 -: addressSize];
    head_uop            = uop_t'(head_entry[UOP_W-1:0]);
    bus.ready_o         = fifo_in_ready;
    bus.valid_o         = head_valid;
    bus.opcode_o        = '0;
    bus.xop_o           = '0;
    bus.reg1_o          = '0;
    bus.reg2_o          = '0;
    bus.reg2ValOrZero_o = 1'b0;
    bus.imm_o           = '0;
    bus.isLoad_o        = 1'b0;
    bus.isStore_o       = 1'b0;
    bus.update_o        = 1'b0;
    bus.signExt_o       = 1'b0;
    bus.size_o          = '0;
    bus.illegal_o       = 1'b0;
    bus.address_o       = '0;
    if (head_valid) begin
      bus.opcode_o        = head_uop.opcode;
      bus.xop_o           = head_uop.xop;
      bus.reg1_o          = head_uop.reg1;
      bus.reg2_o          = head_uop.reg2;
      bus.reg2ValOrZero_o = head_uop.reg2_val_or_zero;
      bus.imm_o           = immOutWidth'($signed(head_uop.imm));
      bus.isLoad_o        = head_uop.is_load;
      bus.isStore_o       = head_uop.is_store;
      bus.update_o        = head_uop.update;
      bus.signExt_o       = head_uop.sign_ext;
      bus.size_o          = head_uop.size;
      bus.illegal_o       = head_uop.illegal;
      bus.address_o       = head_addr;
    end
  end

endmodule

// File: tb/tb_ds_format_decode_stage.sv
// Directed bench for ds_format_decode_stage: two instances, one dropping
// non-DS opcodes and one emitting them as illegal.
module tb_ds_format_decode_stage;

  logic clk;
  logic resetn;
  logic flush;
  int   n_checks;
  int   n_errors;
  logic [63:0] exp_q[$];

  ds_format_decode_stage_if #(.instructionWidth(32), .addressSize(64), .immOutWidth(64)) bus0 ();
  ds_format_decode_stage_if #(.instructionWidth(32), .addressSize(64), .immOutWidth(64)) bus1 ();

  ds_format_decode_stage #(
    .instructionWidth(32), .addressSize(64), .immOutWidth(64), .DEPTH(2), .DROP_NON_DS(1)
  ) dut_drop (
    .clock_i  (clk),
    .resetn_i (resetn),
    .flush_i  (flush),
    .bus      (bus0)
  );

  ds_format_decode_stage #(
    .instructionWidth(32), .addressSize(64), .immOutWidth(64), .DEPTH(2), .DROP_NON_DS(0)
  ) dut_keep (
    .clock_i  (clk),
    .resetn_i (resetn),
    .flush_i  (flush),
    .bus      (bus1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: offer one instruction to dut_drop and let it be accepted
  task automatic send(input string tag, input logic [31:0] instr, input logic [63:0] addr);
    bus0.valid_i       = 1'b1;
    bus0.instruction_i = instr;
    bus0.address_i     = addr;
    #1;
    check_val({tag, ".ready_o"}, 64'(bus0.ready_o), 64'd1);
    cycle();
    bus0.valid_i = 1'b0;
    #1;
  endtask

  task automatic check_head(input string tag,
                            input logic [63:0] opc, input logic [63:0] xop,
                            input logic [63:0] r1, input logic [63:0] r2,
                            input logic [63:0] r0z, input logic [63:0] imm,
                            input logic [63:0] ld, input logic [63:0] st,
                            input logic [63:0] upd, input logic [63:0] sx,
                            input logic [63:0] size, input logic [63:0] ill,
                            input logic [63:0] addr);
    check_val({tag, ".valid_o"},   64'(bus0.valid_o), 64'd1);
    check_val({tag, ".opcode_o"},  64'(bus0.opcode_o), opc);
    check_val({tag, ".xop_o"},     64'(bus0.xop_o), xop);
    check_val({tag, ".reg1_o"},    64'(bus0.reg1_o), r1);
    check_val({tag, ".reg2_o"},    64'(bus0.reg2_o), r2);
    check_val({tag, ".r0z_o"},     64'(bus0.reg2ValOrZero_o), r0z);
    check_val({tag, ".imm_o"},     bus0.imm_o, imm);
    check_val({tag, ".isLoad_o"},  64'(bus0.isLoad_o), ld);
    check_val({tag, ".isStore_o"}, 64'(bus0.isStore_o), st);
    check_val({tag, ".update_o"},  64'(bus0.update_o), upd);
    check_val({tag, ".signExt_o"}, 64'(bus0.signExt_o), sx);
    check_val({tag, ".size_o"},    64'(bus0.size_o), size);
    check_val({tag, ".illegal_o"}, 64'(bus0.illegal_o), ill);
    check_val({tag, ".address_o"}, bus0.address_o, addr);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetn = 1'b0;
    flush  = 1'b0;
    bus0.valid_i = 1'b0; bus0.instruction_i = '0; bus0.address_i = '0; bus0.ready_i = 1'b0;
    bus1.valid_i = 1'b0; bus1.instruction_i = '0; bus1.address_i = '0; bus1.ready_i = 1'b0;

    // Reset state
    repeat (3) cycle();
    check_val("rst.valid_o",   64'(bus0.valid_o), 64'd0);
    check_val("rst.ready_o",   64'(bus0.ready_o), 64'd0);
    check_val("rst.opcode_o",  64'(bus0.opcode_o), 64'd0);
    check_val("rst.imm_o",     bus0.imm_o, 64'd0);
    check_val("rst.address_o", bus0.address_o, 64'd0);
    check_val("rst.valid1_o",  64'(bus1.valid_o), 64'd0);
    resetn = 1'b1;
    #1;
    check_val("rst_release.ready_o", 64'(bus0.ready_o), 64'd1);

    // Decode of each form, consumer always ready
    bus0.ready_i = 1'b1;
    send("ld", 32'hE861_0008, 64'h1000);
    check_head("ld", 58, 0, 3, 1, 1, 64'd8, 1, 0, 0, 0, 3, 0, 64'h1000);
    cycle();
    check_val("ld_pop.valid_o", 64'(bus0.valid_o), 64'd0);
    send("std", 32'hF8A1_FFF0, 64'h1004);
    check_head("std", 62, 0, 5, 1, 1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 1, 0, 0, 3, 0, 64'h1004);
    send("lwa", 32'hE882_0006, 64'h1008);
    check_head("lwa", 58, 2, 4, 2, 1, 64'd4, 1, 0, 0, 1, 2, 0, 64'h1008);
    send("ldu_ra0", 32'hE860_0009, 64'h100C);
    check_head("ldu_ra0", 58, 1, 3, 0, 0, 64'd8, 1, 0, 1, 0, 3, 1, 64'h100C);
    send("ldu_rart", 32'hE863_0001, 64'h1010);
    check_head("ldu_rart", 58, 1, 3, 3, 0, 64'd0, 1, 0, 1, 0, 3, 1, 64'h1010);
    send("stq_odd", 32'hF8A1_0002, 64'h1014);
    check_head("stq_odd", 62, 2, 5, 1, 1, 64'd0, 0, 1, 0, 0, 4, 1, 64'h1014);
    send("stq_even", 32'hF881_0002, 64'h1018);
    check_head("stq_even", 62, 2, 4, 1, 1, 64'd0, 0, 1, 0, 0, 4, 0, 64'h1018);
    send("stdu_ra0", 32'hF8A0_0001, 64'h101C);
    check_head("stdu_ra0", 62, 1, 5, 0, 0, 64'd0, 0, 1, 1, 0, 3, 1, 64'h101C);
    send("ld_xop3", 32'hE861_0003, 64'h1020);
    check_head("ld_xop3", 58, 3, 3, 1, 0, 64'd0, 0, 0, 0, 0, 0, 1, 64'h1020);
    cycle();
    check_val("drain.valid_o", 64'(bus0.valid_o), 64'd0);

    // Backpressure: three back-to-back offers into a two-entry queue
    bus0.ready_i = 1'b0;
    exp_q.delete();
    bus0.valid_i = 1'b1; bus0.instruction_i = 32'hE861_0008; bus0.address_i = 64'h2000;
    #1;
    check_val("bp0.ready_o", 64'(bus0.ready_o), 64'd1);
    cycle();
    exp_q.push_back(64'h2000);
    check_val("bp0.valid_o", 64'(bus0.valid_o), 64'd1);
    bus0.instruction_i = 32'hF8A1_FFF0; bus0.address_i = 64'h2004;
    #1;
    check_val("bp1.ready_o", 64'(bus0.ready_o), 64'd1);
    cycle();
    exp_q.push_back(64'h2004);
    bus0.instruction_i = 32'hE882_0006; bus0.address_i = 64'h2008;
    #1;
    check_val("bp_full.ready_o", 64'(bus0.ready_o), 64'd0);
    cycle();
    check_val("bp_hold1.address_o", bus0.address_o, 64'h2000);
    check_val("bp_hold1.opcode_o",  64'(bus0.opcode_o), 64'd58);
    check_val("bp_hold1.imm_o",     bus0.imm_o, 64'd8);
    cycle();
    check_val("bp_hold2.address_o", bus0.address_o, 64'h2000);
    check_val("bp_hold2.reg1_o",    64'(bus0.reg1_o), 64'd3);
    check_val("bp_hold2.ready_o",   64'(bus0.ready_o), 64'd0);
    bus0.ready_i = 1'b1;
    #1;
    check_val("bp_pushpop.ready_o", 64'(bus0.ready_o), 64'd1);
    check_val("bp_pushpop.address_o", bus0.address_o, exp_q.pop_front());
    cycle();
    exp_q.push_back(64'h2008);
    bus0.valid_i = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      check_val("bp_order.valid_o", 64'(bus0.valid_o), 64'd1);
      check_val("bp_order.address_o", bus0.address_o, exp_q.pop_front());
      cycle();
    end
    check_val("bp_done.valid_o", 64'(bus0.valid_o), 64'd0);

    // Non-DS opcode 31: dropped by one instance, emitted illegal by the other
    send("nonds_drop", 32'h7C00_0000, 64'h3000);
    check_val("nonds_drop.valid_o", 64'(bus0.valid_o), 64'd0);
    cycle();
    check_val("nonds_drop2.valid_o", 64'(bus0.valid_o), 64'd0);
    bus1.ready_i = 1'b1;
    bus1.valid_i = 1'b1; bus1.instruction_i = 32'h7C00_0000; bus1.address_i = 64'h3000;
    #1;
    check_val("nonds_keep.ready_o", 64'(bus1.ready_o), 64'd1);
    cycle();
    bus1.valid_i = 1'b0;
    check_val("nonds_keep.valid_o",   64'(bus1.valid_o), 64'd1);
    check_val("nonds_keep.illegal_o", 64'(bus1.illegal_o), 64'd1);
    check_val("nonds_keep.isLoad_o",  64'(bus1.isLoad_o), 64'd0);
    check_val("nonds_keep.isStore_o", 64'(bus1.isStore_o), 64'd0);
    check_val("nonds_keep.opcode_o",  64'(bus1.opcode_o), 64'd31);
    check_val("nonds_keep.address_o", bus1.address_o, 64'h3000);
    cycle();
    check_val("nonds_keep_pop.valid_o", 64'(bus1.valid_o), 64'd0);

    // Flush of a full queue together with an offered input
    bus0.ready_i = 1'b0;
    bus0.valid_i = 1'b1; bus0.instruction_i = 32'hE861_0008; bus0.address_i = 64'h4000;
    cycle();
    bus0.instruction_i = 32'hF8A1_FFF0; bus0.address_i = 64'h4004;
    cycle();
    bus0.valid_i = 1'b0;
    #1;
    check_val("fl_full.valid_o", 64'(bus0.valid_o), 64'd1);
    check_val("fl_full.ready_o", 64'(bus0.ready_o), 64'd0);
    flush = 1'b1;
    bus0.valid_i = 1'b1; bus0.instruction_i = 32'hE882_0006; bus0.address_i = 64'h4008;
    #1;
    check_val("fl_active.ready_o", 64'(bus0.ready_o), 64'd0);
    cycle();
    flush = 1'b0;
    bus0.valid_i = 1'b0;
    #1;
    check_val("fl_after.valid_o", 64'(bus0.valid_o), 64'd0);
    check_val("fl_after.ready_o", 64'(bus0.ready_o), 64'd1);
    cycle();
    check_val("fl_nocapture.valid_o", 64'(bus0.valid_o), 64'd0);
    bus0.ready_i = 1'b1;
    send("fl_resume", 32'hE861_0008, 64'h4010);
    check_val("fl_resume.address_o", bus0.address_o, 64'h4010);
    cycle();

    // Reset asserted mid-stream
    bus0.ready_i = 1'b0;
    send("rst_mid", 32'hE882_0006, 64'h5000);
    check_val("rst_mid.valid_o", 64'(bus0.valid_o), 64'd1);
    resetn = 1'b0;
    #1;
    check_val("rst_mid_asserted.ready_o", 64'(bus0.ready_o), 64'd0);
    check_val("rst_mid_asserted.valid_o", 64'(bus0.valid_o), 64'd0);
    cycle();
    cycle();
    check_val("rst_mid_held.ready_o",   64'(bus0.ready_o), 64'd0);
    check_val("rst_mid_held.address_o", bus0.address_o, 64'd0);
    resetn = 1'b1;
    #1;
    check_val("rst_mid_release.ready_o", 64'(bus0.ready_o), 64'd1);
    cycle();
    check_val("rst_mid_release.valid_o", 64'(bus0.valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
